// File: rtl/match_sequencer_pkg.sv
// Shared types for the match sequencer: phase encoding, winner codes, health width.
package match_sequencer_pkg;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_LOAD      = 3'd1,
        PH_COUNT     = 3'd2,
        PH_FIGHT     = 3'd3,
        PH_ROUND_END = 3'd4,
        PH_MATCH_END = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_DRAW = 2'd3
    } winner_e;

    localparam int HEALTH_W = 9;

    // Larger score wins; a tie is a draw. Used for timeouts and for the match result.
    function automatic winner_e score_winner(input logic [HEALTH_W-1:0] a,
                                             input logic [HEALTH_W-1:0] b);
        if (a > b) return WIN_P1;
        if (b > a) return WIN_P2;
        return WIN_DRAW;
    endfunction

endpackage

// File: rtl/match_sequencer_sec_tick_gen.sv
// Frame-to-second divider: counts frame ticks modulo FRAMES_PER_S and pulses
// o_sec on the tick that completes a second. i_clear restarts the second.
module sec_tick_gen
    import match_sequencer_pkg::*;
#(
    parameter int FRAMES_PER_S = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_frame_tick,
    output logic o_sec
);

    localparam int CW = (FRAMES_PER_S > 1) ? $clog2(FRAMES_PER_S) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_S - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clear)
            r_cnt <= '0;
        else if (i_frame_tick)
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end

    assign o_sec = i_frame_tick && !i_clear && !reset && (r_cnt == LAST);

endmodule

// File: rtl/match_sequencer.sv
// Round/match controller: phase FSM, hit arbitration with per-victim i-frames,
// round/match winner tracking. Define ROUND_TIMER_EN to run the round clock with timeouts.
module match_sequencer
    import match_sequencer_pkg::*;
#(
    parameter int FRAMES_PER_S     = 60,
    parameter int COUNTDOWN_S      = 3,
    parameter int ROUND_TIME_S     = 99,
    parameter int IFRAMES          = 30,
    parameter int ROUND_END_FRAMES = 120,
    parameter int ROUNDS_TO_WIN    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                start_btn,
    input  logic [HEALTH_W-1:0] health_1,
    input  logic [HEALTH_W-1:0] health_2,
    input  logic                hit_req_1,
    input  logic                hit_req_2,
    output logic                hit_grant_1,
    output logic                hit_grant_2,
    output logic                health_reload,
    output logic                fight_en,
    output logic [2:0]          phase,
    output logic [1:0]          countdown,
    output logic [6:0]          timer_s,
    output logic [2:0]          round_num,
    output logic [1:0]          wins_1,
    output logic [1:0]          wins_2,
    output logic [1:0]          round_winner,
    output logic [1:0]          match_winner
);

    localparam int IW = $clog2(IFRAMES + 1);
    localparam int EW = $clog2(ROUND_END_FRAMES + 1);
    localparam logic [IW-1:0] IFR_LD   = IW'(IFRAMES);
    localparam logic [EW-1:0] END_LAST = EW'(ROUND_END_FRAMES - 1);
    localparam logic [6:0]    RT_INIT  = 7'(ROUND_TIME_S);
    localparam logic [1:0]    CD_INIT  = 2'(COUNTDOWN_S);
    localparam logic [1:0]    WIN_CNT  = 2'(ROUNDS_TO_WIN);
    localparam logic [2:0]    LAST_RND = 3'(2 * ROUNDS_TO_WIN - 1);

    phase_e        r_phase;
    logic [1:0]    r_countdown;
    logic [6:0]    r_timer;
    logic [2:0]    r_round;
    logic [1:0]    r_wins_1;
    logic [1:0]    r_wins_2;
    winner_e       r_round_winner;
    winner_e       r_match_winner;
    logic [EW-1:0] r_end_cnt;
    logic          r_start_q;
    logic          r_grant_1;
    logic          r_grant_2;
    logic [IW-1:0] r_inv_1;
    logic [IW-1:0] r_inv_2;

    logic    w_sec;
    logic    w_timeout;
    logic    w_round_end;
    winner_e w_round_win;
    logic    w_match_done;
    logic    w_elig_1;
    logic    w_elig_2;

    // One divider serves both the countdown and the round clock; LOAD realigns it.
    sec_tick_gen #(
        .FRAMES_PER_S (FRAMES_PER_S)
    ) u_sec (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (r_phase == PH_LOAD),
        .i_frame_tick (frame_tick),
        .o_sec        (w_sec)
    );

`ifdef ROUND_TIMER_EN
    assign w_timeout = (r_timer == 7'd0);
`else
    assign w_timeout = 1'b0;
`endif

    // KO checks come first so a simultaneous timeout resolves the same way.
    always_comb begin
        w_round_end = 1'b1;
        w_round_win = WIN_NONE;
        if (health_1 == '0 && health_2 == '0)
            w_round_win = WIN_DRAW;
        else if (health_2 == '0)
            w_round_win = WIN_P1;
        else if (health_1 == '0)
            w_round_win = WIN_P2;
        else if (w_timeout)
            w_round_win = score_winner(health_1, health_2);
        else
            w_round_end = 1'b0;
    end

    assign w_match_done = (r_wins_1 == WIN_CNT) || (r_wins_2 == WIN_CNT) ||
                          (r_round == LAST_RND);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase        <= PH_IDLE;
            r_countdown    <= CD_INIT;
            r_timer        <= RT_INIT;
            r_round        <= 3'd1;
            r_wins_1       <= 2'd0;
            r_wins_2       <= 2'd0;
            r_round_winner <= WIN_NONE;
            r_match_winner <= WIN_NONE;
            r_end_cnt      <= '0;
            r_start_q      <= 1'b0;
        end else begin
            r_start_q <= start_btn;
            case (r_phase)
                PH_IDLE: begin
                    r_wins_1       <= 2'd0;
                    r_wins_2       <= 2'd0;
                    r_round_winner <= WIN_NONE;
                    r_match_winner <= WIN_NONE;
                    r_round        <= 3'd1;
                    if (start_btn)
                        r_phase <= PH_LOAD;
                end
                PH_LOAD: begin
                    r_round_winner <= WIN_NONE;
                    r_timer        <= RT_INIT;
                    r_countdown    <= CD_INIT;
                    r_phase        <= PH_COUNT;
                end
                PH_COUNT: begin
                    if (w_sec) begin
                        if (r_countdown <= 2'd1) begin
                            r_countdown <= 2'd0;
                            r_phase     <= PH_FIGHT;
                        end else begin
                            r_countdown <= r_countdown - 2'd1;
                        end
                    end
                end
                PH_FIGHT: begin
`ifdef ROUND_TIMER_EN
                    if (w_sec && r_timer != 7'd0)
                        r_timer <= r_timer - 7'd1;
`endif
                    if (w_round_end) begin
                        r_round_winner <= w_round_win;
                        if (w_round_win == WIN_P1)
                            r_wins_1 <= r_wins_1 + 2'd1;
                        if (w_round_win == WIN_P2)
                            r_wins_2 <= r_wins_2 + 2'd1;
                        r_end_cnt <= '0;
                        r_phase   <= PH_ROUND_END;
                    end
                end
                PH_ROUND_END: begin
                    if (frame_tick) begin
                        if (r_end_cnt == END_LAST) begin
                            if (w_match_done) begin
                                r_match_winner <= score_winner(HEALTH_W'(r_wins_1),
                                                               HEALTH_W'(r_wins_2));
                                r_phase        <= PH_MATCH_END;
                            end else begin
                                r_round <= r_round + 3'd1;
                                r_phase <= PH_LOAD;
                            end
                        end else begin
                            r_end_cnt <= r_end_cnt + EW'(1);
                        end
                    end
                end
                PH_MATCH_END: begin
                    if (start_btn && !r_start_q) begin
                        r_wins_1       <= 2'd0;
                        r_wins_2       <= 2'd0;
                        r_match_winner <= WIN_NONE;
                        r_round        <= 3'd1;
                        r_phase        <= PH_LOAD;
                    end
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

    // r_inv_N is the i-frame window of player N as a victim.
    assign w_elig_1 = (r_phase == PH_FIGHT) && hit_req_1 && (r_inv_2 == '0);
    assign w_elig_2 = (r_phase == PH_FIGHT) && hit_req_2 && (r_inv_1 == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_1 <= 1'b0;
            r_grant_2 <= 1'b0;
            r_inv_1   <= '0;
            r_inv_2   <= '0;
        end else begin
            r_grant_1 <= w_elig_1;
            r_grant_2 <= w_elig_2;
            if (r_phase == PH_LOAD)
                r_inv_2 <= '0;
            else if (w_elig_1)
                r_inv_2 <= IFR_LD;
            else if (frame_tick && r_inv_2 != '0)
                r_inv_2 <= r_inv_2 - IW'(1);
            if (r_phase == PH_LOAD)
                r_inv_1 <= '0;
            else if (w_elig_2)
                r_inv_1 <= IFR_LD;
            else if (frame_tick && r_inv_1 != '0)
                r_inv_1 <= r_inv_1 - IW'(1);
        end
    end

    assign hit_grant_1   = r_grant_1;
    assign hit_grant_2   = r_grant_2;
    assign health_reload = (r_phase == PH_LOAD);
    assign fight_en      = (r_phase == PH_FIGHT);
    assign phase         = r_phase;
    assign countdown     = r_countdown;
    assign timer_s       = r_timer;
    assign round_num     = r_round;
    assign wins_1        = r_wins_1;
    assign wins_2        = r_wins_2;
    assign round_winner  = r_round_winner;
    assign match_winner  = r_match_winner;

endmodule
